// File: rtl/vm_ctrl_pkg.sv
// Shared types and constants for the stack-VM run controller.
package vm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_READ   = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } vm_ctrl_state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int IN_BASE_DEF      = 140;
    localparam int VERDICT_ADDR_DEF = 135;
    localparam int PASS_VAL_DEF     = 2;

endpackage

// File: rtl/vm_dmem_mux.sv
// Data-memory port owner select: the core drives the port while it runs,
// the controller drives it at all other times.
module vm_dmem_mux #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          sel_core,
    input  logic [AW-1:0] ctl_raddr,
    input  logic [AW-1:0] ctl_waddr,
    input  logic          ctl_we,
    input  logic [DW-1:0] ctl_wdata,
    input  logic [AW-1:0] core_raddr,
    input  logic [AW-1:0] core_waddr,
    input  logic          core_we,
    input  logic [DW-1:0] core_wdata,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata
);

    assign mem_raddr = sel_core ? core_raddr : ctl_raddr;
    assign mem_waddr = sel_core ? core_waddr : ctl_waddr;
    assign mem_we    = sel_core ? core_we    : ctl_we;
    assign mem_wdata = sel_core ? core_wdata : ctl_wdata;

endmodule

// File: rtl/vm_run_ctrl.sv
// Run controller for the 8-bit stack VM: loads the input string, runs the
// core until halt or timeout, then reads back the verdict byte.
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// LOAD   | accepting input bytes into data memory
// RUN    | core released, memory port owned by the core
// READ   | verdict address presented to memory
// SAMPLE | registered verdict byte available, pass captured
// DONE   | results held until the next start
module vm_run_ctrl
    import vm_ctrl_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int IN_BASE      = IN_BASE_DEF,
    parameter int IN_MAX       = 64,
    parameter int VERDICT_ADDR = VERDICT_ADDR_DEF,
    parameter int PASS_VAL     = PASS_VAL_DEF,
    parameter int TIMEOUT      = 50000,
    parameter int CW           = 20
) (
    input  logic          eo3,
    input  logic          nF3,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          core_rst,
    input  logic [3:0]    core_op,
    input  logic [AW-1:0] core_raddr,
    input  logic [AW-1:0] core_waddr,
    input  logic          core_we,
    input  logic [DW-1:0] core_wdata,
    output logic [AW-1:0] mem_raddr,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    vm_ctrl_state_t state, state_nxt;
    logic [AW-1:0]  idx;
    logic           op_halt_q;
    logic           in_hs;
    logic           load_end;
    logic           halt_det;
    logic           tc_hit;
    logic           start_ok;
    logic [CW-1:0]  cycles_inc;
    logic [AW-1:0]  ctl_raddr;
    logic [AW-1:0]  ctl_waddr;
    logic [DW-1:0]  ctl_wdata;

    assign in_ready   = (state == ST_LOAD);
    assign in_hs      = in_ready && in_valid;
    assign load_end   = in_hs && (in_last || (idx == AW'(IN_MAX - 1)));
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign cycles_inc = cycles + CW'(1);

    // Two consecutive halt opcodes are required because the core spends one
    // cycle fetching and one executing each instruction.
    assign halt_det = (state == ST_RUN) && (core_op == OP_HALT) && op_halt_q;
    assign tc_hit   = (state == ST_RUN) && (cycles_inc == CW'(TIMEOUT));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   if (load_end) state_nxt = ST_RUN;
            ST_RUN:    if (halt_det || tc_hit) state_nxt = ST_READ;
            ST_READ:   state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = ST_DONE;
            ST_DONE:   if (start) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge eo3 or negedge nF3) begin
        if (!nF3) begin
            state     <= ST_IDLE;
            idx       <= '0;
            op_halt_q <= 1'b0;
            cycles    <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            core_rst  <= (state_nxt != ST_RUN);
            busy      <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN) ||
                         (state_nxt == ST_READ) || (state_nxt == ST_SAMPLE);
            done      <= (state_nxt == ST_DONE);
            op_halt_q <= (state == ST_RUN) && (core_op == OP_HALT);

            if (start_ok) begin
                idx     <= '0;
                cycles  <= '0;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end

            if (in_hs) idx <= idx + AW'(1);

            if (state == ST_RUN) begin
                if (cycles != CW'(TIMEOUT)) cycles <= cycles_inc;
                if (tc_hit && !halt_det) timeout <= 1'b1;
            end

            if (state == ST_SAMPLE)
                pass <= (mem_rdata == DW'(PASS_VAL)) && !timeout;
        end
    end

    assign ctl_waddr = in_ready ? (AW'(IN_BASE) + idx) : '0;
    assign ctl_wdata = in_ready ? in_data : '0;
    assign ctl_raddr = (state == ST_READ) ? AW'(VERDICT_ADDR) : '0;

    vm_dmem_mux #(
        .AW (AW),
        .DW (DW)
    ) u_dmem_mux (
        .sel_core   (state == ST_RUN),
        .ctl_raddr  (ctl_raddr),
        .ctl_waddr  (ctl_waddr),
        .ctl_we     (in_hs),
        .ctl_wdata  (ctl_wdata),
        .core_raddr (core_raddr),
        .core_waddr (core_waddr),
        .core_we    (core_we),
        .core_wdata (core_wdata),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_vm_run_ctrl.sv
// Directed bench for vm_run_ctrl with a behavioural data memory and a
// scripted core that writes a verdict byte and then halts.
module tb_vm_run_ctrl;

    localparam int TMO = 100;

    logic        eo3 = 1'b0;
    logic        nF3 = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        core_rst;
    logic [3:0]  core_op;
    logic [7:0]  core_raddr;
    logic [7:0]  core_waddr;
    logic        core_we;
    logic [7:0]  core_wdata;
    logic [7:0]  mem_raddr;
    logic [7:0]  mem_waddr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [19:0] cycles;

    int total = 0;
    int bad = 0;

    // scripted core
    int unsigned k = 0;
    int unsigned halt_at = 32'hFFFF_FFFF;
    int unsigned wr_at = 32'hFFFF_FFFF;
    logic [7:0]  verdict = 8'h00;

    // bench-side memory and controller-write monitor
    logic [7:0]  mem [256];
    int          wr_cnt = 0;
    logic [7:0]  last_waddr = 8'h00;
    logic [7:0]  src [70];

    vm_run_ctrl #(
        .AW(8), .DW(8), .IN_BASE(140), .IN_MAX(64), .VERDICT_ADDR(135),
        .PASS_VAL(2), .TIMEOUT(TMO), .CW(20)
    ) dut (
        .eo3(eo3), .nF3(nF3), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .core_rst(core_rst), .core_op(core_op),
        .core_raddr(core_raddr), .core_waddr(core_waddr), .core_we(core_we), .core_wdata(core_wdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .cycles(cycles)
    );

    always #5 eo3 = ~eo3;

    always @(posedge eo3) begin
        if (core_rst) k <= 0;
        else          k <= k + 1;
    end

    assign core_op    = (!core_rst && k >= halt_at) ? 4'hF : 4'h0;
    assign core_we    = !core_rst && (k == wr_at);
    assign core_waddr = 8'd135;
    assign core_wdata = verdict;
    assign core_raddr = 8'd0;

    always @(posedge eo3) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
        if (mem_we && core_rst) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_waddr;
        end
    end

    task automatic do_start();
        @(negedge eo3) start = 1'b1;
        @(negedge eo3) start = 1'b0;
    endtask

    task automatic send(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge eo3);
            in_valid = 1'b1;
            in_data  = src[i];
            in_last  = with_last && (i == n - 1);
        end
        @(negedge eo3);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_run(input string name, input bit exp_pass, input bit exp_to, input int exp_cyc);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge eo3);
            n++;
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, done); end
        total++;
        if (pass !== exp_pass) begin bad++; $display("FAIL %s_pass got=%b want=%b", name, pass, exp_pass); end
        total++;
        if (timeout !== exp_to) begin bad++; $display("FAIL %s_timeout got=%b want=%b", name, timeout, exp_to); end
        total++;
        if (cycles !== 20'(exp_cyc)) begin bad++; $display("FAIL %s_cycles got=%0d want=%0d", name, cycles, exp_cyc); end
        total++;
        if (busy !== 1'b0 || core_rst !== 1'b1) begin
            bad++; $display("FAIL %s_idle_flags busy=%b core_rst=%b want busy=0 core_rst=1", name, busy, core_rst);
        end
    endtask

    task automatic test_reset();
        nF3 = 1'b0;
        repeat (3) @(negedge eo3);
        total++;
        if (core_rst !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL reset_ctl core_rst=%b in_ready=%b mem_we=%b want 1,0,0", core_rst, in_ready, mem_we);
        end
        total++;
        if (mem_raddr !== 8'd0 || mem_waddr !== 8'd0 || mem_wdata !== 8'd0) begin
            bad++; $display("FAIL reset_mem raddr=%0d waddr=%0d wdata=%0d want 0", mem_raddr, mem_waddr, mem_wdata);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0 || cycles !== 20'd0) begin
            bad++; $display("FAIL reset_status busy=%b done=%b pass=%b timeout=%b cycles=%0d want all 0",
                            busy, done, pass, timeout, cycles);
        end
        @(negedge eo3) nF3 = 1'b1;
        @(negedge eo3);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_hold in_ready=%b busy=%b want 0,0", in_ready, busy);
        end
    endtask

    task automatic test_pass_run();
        string s;
        int c0;
        int n;
        s = "maple{t}";
        for (int i = 0; i < 8; i++) src[i] = s[i];
        verdict = 8'd2; wr_at = 3; halt_at = 5;
        c0 = wr_cnt;
        do_start();
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || core_rst !== 1'b1) begin
            bad++; $display("FAIL load_entry in_ready=%b busy=%b core_rst=%b want 1,1,1", in_ready, busy, core_rst);
        end
        send(8, 1'b1);
        total++;
        if (core_rst !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL run_entry core_rst=%b in_ready=%b want 0,0", core_rst, in_ready);
        end
        total++;
        if (wr_cnt - c0 !== 8 || last_waddr !== 8'd147) begin
            bad++; $display("FAIL load_writes count=%0d last_addr=%0d want 8,147", wr_cnt - c0, last_waddr);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (mem[140 + i] !== s[i]) begin
                bad++; $display("FAIL load_byte%0d got=%h want=%h", i, mem[140 + i], s[i]);
            end
        end
        n = 0;
        while (core_rst === 1'b0 && n < 200) begin
            @(negedge eo3);
            n++;
        end
        total++;
        if (mem_raddr !== 8'd135 || mem_we !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL read_phase raddr=%0d we=%b done=%b want 135,0,0", mem_raddr, mem_we, done);
        end
        @(negedge eo3);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL sample_phase done=%b busy=%b want 0,1", done, busy);
        end
        @(negedge eo3);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL done_latency done=%b want 1", done); end
        finish_run("pass_run", 1'b1, 1'b0, 7);
    endtask

    task automatic test_fail_verdict();
        src[0] = 8'h41; src[1] = 8'h42; src[2] = 8'h43;
        verdict = 8'd1; wr_at = 2; halt_at = 10;
        do_start();
        send(3, 1'b1);
        finish_run("fail_run", 1'b0, 1'b0, 12);
    endtask

    task automatic test_timeout();
        src[0] = 8'h5A;
        verdict = 8'd2; wr_at = 32'hFFFF_FFFF; halt_at = 32'hFFFF_FFFF;
        do_start();
        send(1, 1'b1);
        finish_run("timeout_run", 1'b0, 1'b1, TMO);
    endtask

    task automatic test_overflow();
        int c0;
        bit seen_drop;
        for (int i = 0; i < 70; i++) src[i] = 8'(i + 48);
        verdict = 8'd2; wr_at = 0; halt_at = 20;
        c0 = wr_cnt;
        seen_drop = 1'b0;
        do_start();
        for (int i = 0; i < 70; i++) begin
            @(negedge eo3);
            if (i == 64 && in_ready === 1'b0) seen_drop = 1'b1;
            in_valid = 1'b1;
            in_data  = src[i];
            in_last  = 1'b0;
        end
        @(negedge eo3);
        in_valid = 1'b0;
        total++;
        if (!seen_drop) begin bad++; $display("FAIL overflow_ready in_ready high after 64th byte, want 0"); end
        total++;
        if (wr_cnt - c0 !== 64 || last_waddr !== 8'd203) begin
            bad++; $display("FAIL overflow_writes count=%0d last_addr=%0d want 64,203", wr_cnt - c0, last_waddr);
        end
        total++;
        if (mem[140] !== 8'd48 || mem[203] !== 8'd111) begin
            bad++; $display("FAIL overflow_bytes first=%0d last=%0d want 48,111", mem[140], mem[203]);
        end
        finish_run("overflow_run", 1'b1, 1'b0, 22);
    endtask

    task automatic test_reset_mid_run();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
        verdict = 8'd2; wr_at = 32'hFFFF_FFFF; halt_at = 32'hFFFF_FFFF;
        do_start();
        send(3, 1'b1);
        repeat (10) @(negedge eo3);
        nF3 = 1'b0;
        #1;
        total++;
        if (core_rst !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || cycles !== 20'd0) begin
            bad++; $display("FAIL async_reset core_rst=%b busy=%b mem_we=%b cycles=%0d want 1,0,0,0",
                            core_rst, busy, mem_we, cycles);
        end
        @(negedge eo3) nF3 = 1'b1;
        wr_at = 1; halt_at = 4;
        do_start();
        send(3, 1'b1);
        finish_run("after_reset", 1'b1, 1'b0, 6);
    endtask

    task automatic test_back_to_back();
        src[0] = 8'h77; src[1] = 8'h78;
        verdict = 8'd2; wr_at = 5; halt_at = 98;
        do_start();
        send(2, 1'b1);
        repeat (5) @(negedge eo3);
        start = 1'b1;
        @(negedge eo3);
        start = 1'b0;
        @(negedge eo3);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || core_rst !== 1'b0) begin
            bad++; $display("FAIL start_in_run in_ready=%b busy=%b core_rst=%b want 0,1,0", in_ready, busy, core_rst);
        end
        finish_run("halt_at_limit", 1'b1, 1'b0, TMO);
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_fail_verdict();
        test_timeout();
        test_overflow();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vm_run_ctrl.md
# vm_run_ctrl

Run controller for the 8-bit stack VM: it owns the shared data-memory port and sequences one complete program run. It streams an input string into data memory, releases the core from reset, and watches for the halt opcode or a cycle timeout. It then reads the verdict byte and reports pass or fail. It sits between the host/testbench and the core/data-memory pair, replacing hierarchical pokes and fixed delays.

## Interface
Parameters:
- AW, 8, data-memory address width
- DW, 8, data-memory data width
- IN_BASE, 140, address of the first input byte
- IN_MAX, 64, maximum number of input bytes
- VERDICT_ADDR, 135, address of the verdict byte
- PASS_VAL, 2, verdict value that means pass
- TIMEOUT, 50000, maximum number of RUN cycles
- CW, 20, width of the cycle counter (must hold TIMEOUT)

Ports:
- eo3  in  1  clock, rising edge
- nF3  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  run request; sampled only in IDLE and DONE
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted; high only in LOAD
- in_data  in  DW  input byte
- in_last  in  1  marks the final input byte
- core_rst  out  1  active-high synchronous reset to the core
- core_op  in  4  high nibble of the core's current instruction
- core_raddr, core_waddr  in  AW  core data-memory addresses
- core_we  in  1  core data-memory write enable
- core_wdata  in  DW  core write data
- mem_raddr, mem_waddr  out  AW  data-memory addresses
- mem_we  out  1  data-memory write enable
- mem_wdata  out  DW  data-memory write data
- mem_rdata  in  DW  data-memory registered read data (one-cycle latency)
- busy  out  1  high in LOAD, RUN, READ and SAMPLE
- done  out  1  high in DONE
- pass  out  1  verdict equalled PASS_VAL and the run did not time out
- timeout  out  1  run ended by cycle limit
- cycles  out  CW  number of RUN cycles in the last run

## Operation
- States: IDLE, LOAD, RUN, READ, SAMPLE, DONE.
- **IDLE**
  - core_rst=1 and the memory port belongs to the controller, with mem_we=0.
  - start moves to LOAD, clears idx, cycles, pass and timeout.
- **LOAD**
  - core_rst=1 and in_ready=1.
  - On each handshake: mem_we=1, mem_waddr=IN_BASE+idx (mod 2^AW), mem_wdata=in_data, idx increments.
  - Move to RUN after the handshake carrying in_last, or after the handshake at idx=IN_MAX-1, whichever comes first.
  - Extra bytes after the IN_MAX limit are not accepted, because in_ready drops.
- **RUN**
  - core_rst=0 and all mem_* signals pass straight through from core_*.
  - cycles increments every RUN cycle and saturates at TIMEOUT.
  - Halt is detected when core_op==4'hF on two consecutive RUN cycles; this covers the core's two-phase fetch/execute.
  - On halt, move to READ.
  - When cycles reaches TIMEOUT, set timeout=1 and move to READ.
  - If halt and timeout occur on the same cycle, halt wins and timeout stays 0.
- **READ**
  - core_rst=1, mem_we=0, mem_raddr=VERDICT_ADDR.
  - Always moves to SAMPLE.
- **SAMPLE**
  - Capture pass = (mem_rdata==PASS_VAL) && !timeout, then move to DONE.
- **DONE**
  - done=1; pass, timeout and cycles are held.
  - start re-enters LOAD, clearing flags as in IDLE.
- start in any busy state is ignored. in_valid outside LOAD is ignored.
- Address arithmetic is modulo 2^AW. Counter comparison is at full CW width.

## Timing
- Reset values: state=IDLE, core_rst=1, in_ready=0, mem_we=0, mem addresses 0, mem_wdata 0, busy=0, done=0, pass=0, timeout=0, cycles=0.
- core_rst and all status outputs are registered.
- in_ready and the mem_* mux are combinational decodes of the registered state.
- start in IDLE → LOAD on the next cycle.
- The last input handshake → RUN on the next cycle, so core_rst falls one cycle after the last write.
- Halt confirmed at edge N → READ in cycle N+1, SAMPLE in N+2, done high from N+3.
- Asserting nF3 mid-run: all registers clear immediately and core_rst goes high asynchronously. The memory port returns to the controller with mem_we=0; an in-flight core write may be lost.
- Zero-length input is not supported: LOAD waits for at least one byte.

## Structure
- The package vm_ctrl_pkg holds:
  - the state enum vm_ctrl_state_t;
  - OP_HALT=4'hF;
  - default constants IN_BASE, VERDICT_ADDR, PASS_VAL.
- Sub-module vm_dmem_mux: a combinational owner select between the controller and core ports. The FSM, counters and halt detector stay in the top module.

## Test plan
- Load "maple{t}" (8 bytes, in_last on the 8th) → 8 writes to addresses 140..147, core_rst falls one cycle later; a program that writes 2 to address 135 and halts → done=1, pass=1, timeout=0.
- Program writes 1 to address 135 and halts → done=1, pass=0, timeout=0, cycles equals the program's cycle count.
- Program loops forever with TIMEOUT=100 → timeout=1, pass=0, cycles=100.
- 70 bytes offered without in_last → exactly 64 accepted (addresses 140..203), in_ready low after the 64th.
- nF3 pulsed low mid-RUN → core_rst=1 and busy=0 immediately; then start plus a reload gives a correct pass.
- start pulsed during RUN, and halt coinciding with cycles==TIMEOUT → start ignored; result timeout=0 and pass taken from the verdict byte.
